// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: round count, FSM state encoding, round constants
// and GF(2^8) helpers (xtime, gmul, field inverse, S-box / inverse S-box).
// Used by both the decryptor and the forward encryptor.
package aes128_pkg;

   localparam int unsigned BLOCK_W = 128;
   localparam int unsigned NR      = 10;
   localparam int unsigned NKEYS   = NR + 1;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_KEYEXP = 2'd1,
      ST_ROUNDS = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   // Index 0 is unused; round key i uses RCON[i].
   localparam logic [7:0] RCON [0:10] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 11; i++) begin
         if (idx == 4'(i)) r = RCON[i];
      end
      return r;
   endfunction

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x4, x8, x16, x32, x64, x128, r;
      x2   = gmul(x,   x);
      x4   = gmul(x2,  x2);
      x8   = gmul(x4,  x4);
      x16  = gmul(x8,  x8);
      x32  = gmul(x16, x16);
      x64  = gmul(x32, x32);
      x128 = gmul(x64, x64);
      r = gmul(x2, x4);
      r = gmul(r, x8);
      r = gmul(r, x16);
      r = gmul(r, x32);
      r = gmul(r, x64);
      r = gmul(r, x128);
      return r;
   endfunction

   // Forward S-box: field inverse followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] v;
      v = gf_inv(b);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   // Inverse S-box: inverse affine transform followed by the field inverse.
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] t;
      t = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
      return gf_inv(t);
   endfunction

endpackage

// File: rtl/aes128_inv_round.sv
// One combinational AES-128 inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped if last_i).
// Ports:
//   state_i  128  current cipher state (bits[127:120] = byte 0)
//   rk_i     128  round key for this round
//   last_i     1  final round, omit InvMixColumns
//   state_o  128  next cipher state
import aes128_pkg::*;

module aes128_inv_round (
   input  logic [BLOCK_W-1:0] state_i,
   input  logic [BLOCK_W-1:0] rk_i,
   input  logic               last_i,
   output logic [BLOCK_W-1:0] state_o
);

   logic [7:0] s_in  [16];
   logic [7:0] s_sh  [16];
   logic [7:0] s_ark [16];
   logic [7:0] s_out [16];

   always_comb begin
      state_o = '0;
      // Byte k sits at row k%4, column k/4.
      for (int k = 0; k < 16; k++) begin
         s_in[k] = state_i[127-8*k -: 8];
      end
      // Row r rotates right by r: s'[r][c] = s[r][(c-r) mod 4].
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            s_sh[r+4*c] = s_in[r + 4*((c + 4 - r) % 4)];
         end
      end
      for (int k = 0; k < 16; k++) begin
         s_ark[k] = inv_sbox(s_sh[k]) ^ rk_i[127-8*k -: 8];
      end
      for (int c = 0; c < 4; c++) begin
         s_out[4*c]   = gmul(s_ark[4*c], 8'h0e) ^ gmul(s_ark[4*c+1], 8'h0b) ^
                        gmul(s_ark[4*c+2], 8'h0d) ^ gmul(s_ark[4*c+3], 8'h09);
         s_out[4*c+1] = gmul(s_ark[4*c], 8'h09) ^ gmul(s_ark[4*c+1], 8'h0e) ^
                        gmul(s_ark[4*c+2], 8'h0b) ^ gmul(s_ark[4*c+3], 8'h0d);
         s_out[4*c+2] = gmul(s_ark[4*c], 8'h0d) ^ gmul(s_ark[4*c+1], 8'h09) ^
                        gmul(s_ark[4*c+2], 8'h0e) ^ gmul(s_ark[4*c+3], 8'h0b);
         s_out[4*c+3] = gmul(s_ark[4*c], 8'h0b) ^ gmul(s_ark[4*c+1], 8'h0d) ^
                        gmul(s_ark[4*c+2], 8'h09) ^ gmul(s_ark[4*c+3], 8'h0e);
         if (last_i) begin
            for (int r = 0; r < 4; r++) s_out[4*c+r] = s_ark[4*c+r];
         end
      end
      for (int k = 0; k < 16; k++) begin
         state_o[127-8*k -: 8] = s_out[k];
      end
   end

endmodule

// File: rtl/aes128_dec.sv
// Iterative AES-128 decryptor. On a load edge the ciphertext and key are
// captured; 10 edges expand the key schedule (the last one also applies the
// initial AddRoundKey with rk10), then 10 edges run inverse rounds using
// rk9..rk0. DONE/PLAINTEXT are held while ENABLE stays high.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   enable_i       level request: high = start/hold, low = abort/release
//   ciphertext_i   128-bit block to decrypt (sampled only on the load edge)
//   key_i          128-bit cipher key (sampled only on the load edge)
//   plaintext_o    registered decrypted block, valid while done_o = 1
//   done_o         registered result-valid flag
import aes128_pkg::*;

module aes128_dec (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic [BLOCK_W-1:0] ciphertext_i,
   input  logic [BLOCK_W-1:0] key_i,
   output logic [BLOCK_W-1:0] plaintext_o,
   output logic               done_o
);

   state_e             fsm_q, fsm_d;
   logic [BLOCK_W-1:0] st_q, st_d;
   logic [BLOCK_W-1:0] pt_q, pt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [BLOCK_W-1:0] rk_q [NKEYS];
   logic [BLOCK_W-1:0] rk_d [NKEYS];

   logic [BLOCK_W-1:0] key_prev;
   logic [BLOCK_W-1:0] key_next;
   logic [BLOCK_W-1:0] rk_cur;
   logic [BLOCK_W-1:0] round_out;
   logic [31:0]        rot_word;
   logic [31:0]        sub_word;
   logic               last_round;

   // Key schedule step rk[cnt] = f(rk[cnt-1]) and round-key selection.
   always_comb begin
      key_prev = '0;
      rk_cur   = '0;
      for (int i = 0; i < int'(NR); i++) begin
         if (cnt_q == CNT_W'(i + 1)) key_prev = rk_q[i];
      end
      for (int i = 0; i < int'(NKEYS); i++) begin
         if (cnt_q == CNT_W'(i)) rk_cur = rk_q[i];
      end
      rot_word = {key_prev[23:0], key_prev[31:24]};
      sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                  sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
      key_next[127:96] = key_prev[127:96] ^ sub_word ^ {rcon(cnt_q), 24'h000000};
      key_next[95:64]  = key_prev[95:64]  ^ key_next[127:96];
      key_next[63:32]  = key_prev[63:32]  ^ key_next[95:64];
      key_next[31:0]   = key_prev[31:0]   ^ key_next[63:32];
   end

   assign last_round = (cnt_q == '0);

   aes128_inv_round u_inv_round (
      .state_i (st_q),
      .rk_i    (rk_cur),
      .last_i  (last_round),
      .state_o (round_out)
   );

   // Next-state and datapath update.
   always_comb begin
      fsm_d  = fsm_q;
      st_d   = st_q;
      pt_d   = pt_q;
      cnt_d  = cnt_q;
      done_d = done_q;
      for (int i = 0; i < int'(NKEYS); i++) rk_d[i] = rk_q[i];

      case (fsm_q)
         ST_IDLE: begin
            done_d = 1'b0;
            if (enable_i) begin
               st_d    = ciphertext_i;
               rk_d[0] = key_i;
               cnt_d   = CNT_W'(1);
               fsm_d   = ST_KEYEXP;
            end
         end
         ST_KEYEXP: begin
            if (!enable_i) begin
               fsm_d = ST_IDLE;
            end else begin
               for (int i = 1; i < int'(NKEYS); i++) begin
                  if (cnt_q == CNT_W'(i)) rk_d[i] = key_next;
               end
               if (cnt_q == CNT_W'(NR)) begin
                  // Initial AddRoundKey folded into the final expansion step.
                  st_d  = st_q ^ key_next;
                  cnt_d = CNT_W'(NR - 1);
                  fsm_d = ST_ROUNDS;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_ROUNDS: begin
            if (!enable_i) begin
               fsm_d = ST_IDLE;
            end else begin
               st_d = round_out;
               if (last_round) begin
                  pt_d   = round_out;
                  done_d = 1'b1;
                  fsm_d  = ST_FINISH;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         ST_FINISH: begin
            if (!enable_i) begin
               done_d = 1'b0;
               fsm_d  = ST_IDLE;
            end
         end
         default: begin
            fsm_d  = ST_IDLE;
            done_d = 1'b0;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fsm_q  <= ST_IDLE;
         st_q   <= '0;
         pt_q   <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
         for (int i = 0; i < int'(NKEYS); i++) rk_q[i] <= '0;
      end else begin
         fsm_q  <= fsm_d;
         st_q   <= st_d;
         pt_q   <= pt_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
         for (int i = 0; i < int'(NKEYS); i++) rk_q[i] <= rk_d[i];
      end
   end

   assign plaintext_o = pt_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_aes128_dec.sv
// Testbench for aes128_dec using published AES-128 vectors and a queue of
// expected plaintexts.
module tb_aes128_dec;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic [127:0] ciphertext;
   logic [127:0] key;
   logic [127:0] plaintext;
   logic         done;

   localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] PT_Z  = 128'h0;

   int n_checks = 0;
   int n_fail   = 0;
   logic [127:0] exp_q [$];

   always #5 clk = ~clk;

   aes128_dec dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .enable_i     (enable),
      .ciphertext_i (ciphertext),
      .key_i        (key),
      .plaintext_o  (plaintext),
      .done_o       (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request; the next edge is the load edge.
   task automatic do_load(input logic [127:0] k, input logic [127:0] ct,
                          input logic [127:0] expv, input bit track);
      key        = k;
      ciphertext = ct;
      enable     = 1'b1;
      if (track) exp_q.push_back(expv);
      tick();
   endtask

   // Edges counted from the load edge until done rises; -1 on timeout.
   task automatic run_to_done(input int start, output int lat);
      lat = -1;
      for (int n = start + 1; n <= start + 40; n++) begin
         tick();
         if (done === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic pop_exp(output logic [127:0] e);
      if (exp_q.size() == 0) e = 'x;
      else e = exp_q.pop_front();
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; key = '0; ciphertext = '0;
      repeat (3) tick();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL reset_done: got %b expected 0", done);
      end
      n_checks++;
      if (plaintext !== 128'h0) begin
         n_fail++; $display("FAIL reset_pt: got %h expected 0", plaintext);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fips_c1();
      int lat;
      logic [127:0] e;
      do_load(K_C1, CT_C1, PT_C1, 1'b1);
      run_to_done(0, lat);
      n_checks++;
      if (lat !== 20) begin
         n_fail++; $display("FAIL c1_latency: got %0d expected 20", lat);
      end
      pop_exp(e);
      n_checks++;
      if (plaintext !== e) begin
         n_fail++; $display("FAIL c1_pt: got %h expected %h", plaintext, e);
      end
      // Enable held high: result holds, no restart.
      key = K_B; ciphertext = CT_B;
      for (int i = 0; i < 25; i++) begin
         tick();
         n_checks++;
         if (done !== 1'b1 || plaintext !== e) begin
            n_fail++; $display("FAIL c1_hold[%0d]: got done=%b pt=%h expected done=1 pt=%h", i, done, plaintext, e);
         end
      end
      enable = 1'b0;
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL c1_release: got done=%b expected 0", done);
      end
   endtask

   task automatic test_app_b();
      int lat;
      logic [127:0] e;
      do_load(K_B, CT_B, PT_B, 1'b1);
      run_to_done(0, lat);
      n_checks++;
      if (lat !== 20) begin
         n_fail++; $display("FAIL appb_latency: got %0d expected 20", lat);
      end
      pop_exp(e);
      n_checks++;
      if (plaintext !== e) begin
         n_fail++; $display("FAIL appb_pt: got %h expected %h", plaintext, e);
      end
      enable = 1'b0;
      tick();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL appb_done_fall: got %b expected 0", done);
      end
      n_checks++;
      if (plaintext !== PT_B) begin
         n_fail++; $display("FAIL appb_pt_retained: got %h expected %h", plaintext, PT_B);
      end
      tick();
   endtask

   task automatic test_zero_key();
      int lat;
      logic [127:0] e;
      do_load(128'h0, CT_Z, PT_Z, 1'b1);
      repeat (4) tick();
      // Inputs change ahead of edge 5 after the load; result must not move.
      key        = {$urandom, $urandom, $urandom, $urandom};
      ciphertext = {$urandom, $urandom, $urandom, $urandom};
      run_to_done(4, lat);
      n_checks++;
      if (lat !== 20) begin
         n_fail++; $display("FAIL zero_latency: got %0d expected 20", lat);
      end
      pop_exp(e);
      n_checks++;
      if (plaintext !== e) begin
         n_fail++; $display("FAIL zero_pt: got %h expected %h", plaintext, e);
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      int lat;
      logic [127:0] e;
      do_load(K_C1, CT_C1, 128'h0, 1'b0);
      for (int i = 1; i <= 13; i++) begin
         tick();
         n_checks++;
         if (done !== 1'b0) begin
            n_fail++; $display("FAIL abort_run[%0d]: got done=%b expected 0", i, done);
         end
      end
      enable = 1'b0;
      for (int i = 14; i < 26; i++) begin
         tick();
         n_checks++;
         if (done !== 1'b0 || plaintext !== PT_Z) begin
            n_fail++; $display("FAIL abort_idle[%0d]: got done=%b pt=%h expected done=0 pt=%h", i, done, plaintext, PT_Z);
         end
      end
      do_load(K_C1, CT_C1, PT_C1, 1'b1);
      run_to_done(0, lat);
      n_checks++;
      if (lat !== 20) begin
         n_fail++; $display("FAIL abort_restart_latency: got %0d expected 20", lat);
      end
      pop_exp(e);
      n_checks++;
      if (plaintext !== e) begin
         n_fail++; $display("FAIL abort_restart_pt: got %h expected %h", plaintext, e);
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      int lat;
      logic [127:0] e;
      do_load(K_B, CT_B, 128'h0, 1'b0);
      repeat (6) tick();
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL async_rst_done: got %b expected 0", done);
      end
      n_checks++;
      if (plaintext !== 128'h0) begin
         n_fail++; $display("FAIL async_rst_pt: got %h expected 0", plaintext);
      end
      // Release between edges with enable still high: next edge loads.
      key = K_C1; ciphertext = CT_C1;
      @(posedge clk);
      #3;
      rst = 1'b0;
      exp_q.push_back(PT_C1);
      run_to_done(-1, lat);
      n_checks++;
      if (lat !== 20) begin
         n_fail++; $display("FAIL async_rst_latency: got %0d expected 20", lat);
      end
      pop_exp(e);
      n_checks++;
      if (plaintext !== e) begin
         n_fail++; $display("FAIL async_rst_pt_after: got %h expected %h", plaintext, e);
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [127:0] e;
      do_load(K_B, CT_B, PT_B, 1'b1);
      run_to_done(0, lat);
      pop_exp(e);
      n_checks++;
      if (lat !== 20 || plaintext !== e) begin
         n_fail++; $display("FAIL b2b_first: got lat=%0d pt=%h expected lat=20 pt=%h", lat, plaintext, e);
      end
      enable = 1'b0;
      tick();
      do_load(128'h0, CT_Z, PT_Z, 1'b1);
      run_to_done(0, lat);
      pop_exp(e);
      n_checks++;
      if (lat !== 20 || plaintext !== e) begin
         n_fail++; $display("FAIL b2b_second: got lat=%0d pt=%h expected lat=20 pt=%h", lat, plaintext, e);
      end
      enable = 1'b0;
      tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_fips_c1();
      test_app_b();
      test_zero_key();
      test_abort();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes128_dec.md
AES128_DEC -- requirements
Module: aes128_dec

Interface
REQ-001 SHALL have no parameters; the block is fixed at AES-128 (10 rounds).
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 ENABLE  input  1  level request; high = start or hold the operation, low = abort or release.
REQ-005 CIPHERTEXT  input  128  block to decrypt; bits[127:120] = FIPS-197 byte 0.
REQ-006 KEY  input  128  cipher key; same byte order as CIPHERTEXT.
REQ-007 PLAINTEXT  output  128  decrypted block, registered; valid only while DONE=1.
REQ-008 DONE  output  1  registered; high = PLAINTEXT valid.

Function
REQ-009 SHALL implement the FIPS-197 AES-128 inverse cipher.
- Output: PLAINTEXT = AES128_decrypt(KEY, CIPHERTEXT).
REQ-010 FSM states SHALL be IDLE, KEYEXP, ROUNDS, FINISH.
REQ-011 Load edge: IDLE with ENABLE=1 at an edge SHALL:
- latch CIPHERTEXT into the state register and KEY into round-key slot 0;
- clear the counter to 1 and go to KEYEXP.
- CIPHERTEXT and KEY SHALL be ignored on every other edge.
REQ-012 KEYEXP SHALL compute round key rk[cnt] from rk[cnt-1] each edge, using RotWord, SubWord and Rcon.
- Stores rk1..rk10 in 11 x 128-bit registers over 10 edges.
- On the edge producing rk10, it SHALL also XOR rk10 into the state, set cnt=9 and go to ROUNDS.
REQ-013 ROUNDS: each edge SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(rk[cnt]), then InvMixColumns.
- InvMixColumns SHALL be omitted when cnt=0.
- cnt decrements; the edge with cnt=0 SHALL go to FINISH.
REQ-014 Entering FINISH SHALL set DONE=1 with PLAINTEXT = final state.
- Both SHALL hold while ENABLE=1.
REQ-015 Latency: DONE SHALL rise exactly 20 clock edges after the load edge (10 KEYEXP + 10 ROUNDS).
REQ-016 ENABLE=0 sampled in KEYEXP or ROUNDS SHALL abort to IDLE; DONE stays 0 and PLAINTEXT is unchanged.
REQ-017 ENABLE=0 sampled in FINISH SHALL return to IDLE and clear DONE on that edge; PLAINTEXT retains its value.
REQ-018 A new operation SHALL require ENABLE to be low for at least one edge after FINISH.
- ENABLE held high never restarts the block.
REQ-019 KEY or CIPHERTEXT changing mid-operation SHALL NOT affect the result.

Reset
REQ-020 RESET=1 SHALL immediately force state=IDLE and DONE=0, regardless of CLK.
- Also clears PLAINTEXT, the cipher state, the counter and all round-key registers to 0.
REQ-021 RESET asserted mid-operation SHALL discard the operation.
- After release, a load SHALL occur only on an edge with ENABLE=1.
REQ-022 Release of RESET with ENABLE already high SHALL start an operation on the first edge after release.

Structure
REQ-023 Shared package aes128_pkg SHALL hold:
- SBOX and INV_SBOX as functions or constant tables;
- the RCON table, the xtime/gmul helper functions and the FSM state enum typedef.
- The forward encryptor SHALL use the same package.
REQ-024 The block SHALL contain one sub-module, aes128_inv_round.
- Combinational: inputs are the state, the round key and a last-round flag.
- Output is the next state.
REQ-025 Key expansion SHALL be inline; no other sub-modules.

Verification
REQ-026 FIPS-197 C.1: KEY=000102030405060708090a0b0c0d0e0f, CIPHERTEXT=69c4e0d86a7b0430d8cdb78070b4c55a, ENABLE held high.
- Expect PLAINTEXT=00112233445566778899aabbccddeeff with DONE rising exactly 20 edges after the load edge.
REQ-027 FIPS-197 App. B: KEY=2b7e151628aed2a6abf7158809cf4f3c, CIPHERTEXT=3925841d02dc09fbdc118597196a0b32.
- Expect PLAINTEXT=3243f6a8885a308d313198a2e0370734.
- Then drop ENABLE: DONE falls on the next edge and PLAINTEXT is unchanged.
REQ-028 Zero key: KEY=0, CIPHERTEXT=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Expect PLAINTEXT=0.
- Change KEY and CIPHERTEXT to random values on edge 5 after load: the result is unchanged.
REQ-029 Abort: start the C.1 vector and drop ENABLE at edge 14.
- Expect IDLE and DONE=0 throughout.
- Re-raise ENABLE: the correct result arrives 20 edges after the new load edge.
REQ-030 Reset: assert RESET asynchronously between edges at cycle 7 of an operation.
- DONE and PLAINTEXT go to 0 immediately.
- After release with ENABLE high, a full operation completes correctly in 20 edges.
